// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC register, imem req/ready, decode buffer
// Optional misaligned-fetch trap enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        id_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] stale_addr_q, stale_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        addr_err_q, addr_err_d;
    logic        fetch_misaligned;

`ifdef IF_ALIGN_CHECK_EN
    assign fetch_misaligned = |pc_q[1:0];
`else
    assign fetch_misaligned = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        stale_addr_d  = stale_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        addr_err_d    = addr_err_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_misaligned) begin
                    // No request was issued, so nothing is in flight to discard.
                    if (flush) begin
                        pc_d = flush_pc;
                    end else begin
                        instr_d       = 32'h0000_0000;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        addr_err_d    = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (flush) begin
                    pc_d = flush_pc;
                    if (!imem_ready) begin
                        stale_addr_d = {pc_q[31:2], 2'b00};
                        state_d      = S_DISCARD;
                    end
                end else if (imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d          = flush_pc;
                    instr_valid_d = 1'b0;
                    addr_err_d    = 1'b0;
                    state_d       = S_FETCH;
                end else if (id_ready) begin
                    pc_d          = npc;
                    instr_valid_d = 1'b0;
                    addr_err_d    = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (imem_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            stale_addr_q  <= 32'h0000_0000;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            stale_addr_q  <= stale_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // Address comes straight from registers; DISCARD keeps presenting the abandoned request.
    assign imem_addr   = (state_q == S_DISCARD) ? stale_addr_q : {pc_q[31:2], 2'b00};
    assign imem_req    = !rst && ((state_q == S_DISCARD) ||
                                  ((state_q == S_FETCH) && !fetch_misaligned));
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized + directed bench for if_fetch_stage with reference model
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst, flush, imem_ready, id_ready;
    logic [31:0] npc, flush_pc, imem_rdata;
    logic [31:0] pc, imem_addr, instr, instr_pc;
    logic        imem_req, instr_valid, addr_err;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: what the fetch stage is holding / waiting for.
    logic [31:0] m_pc, m_instr, m_ipc, m_stale;
    logic        m_valid, m_discard, m_err;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .npc(npc), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .id_ready(id_ready), .flush(flush),
        .flush_pc(flush_pc), .addr_err(addr_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic align_bad(input logic [31:0] p);
`ifdef IF_ALIGN_CHECK_EN
        return |p[1:0];
`else
        return (p[0] & 1'b0);
`endif
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_discard ? m_stale : {m_pc[31:2], 2'b00};
    endfunction

    function automatic logic exp_req();
        return !rst && !m_valid && (m_discard || !align_bad(m_pc));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = '0; m_ipc = '0; m_stale = '0;
        m_valid = 1'b0; m_discard = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_valid) begin
            if (flush || id_ready) begin
                m_valid = 1'b0;
                m_err   = 1'b0;
                m_pc    = flush ? flush_pc : npc;
            end
        end else if (m_discard) begin
            if (flush) m_pc = flush_pc;
            if (imem_ready) m_discard = 1'b0;
        end else if (align_bad(m_pc)) begin
            if (flush) m_pc = flush_pc;
            else begin
                m_valid = 1'b1; m_instr = '0; m_ipc = m_pc; m_err = 1'b1;
            end
        end else if (flush) begin
            if (!imem_ready) begin
                m_discard = 1'b1;
                m_stale   = {m_pc[31:2], 2'b00};
            end
            m_pc = flush_pc;
        end else if (imem_ready) begin
            m_valid = 1'b1; m_instr = imem_rdata; m_ipc = m_pc;
        end
    endtask

    // One clock: inputs applied at negedge, outputs checked 1 time unit later, model advances at posedge.
    task automatic drv(input logic r, input logic f, input logic [31:0] fpc,
                       input logic rdy, input logic idr, input logic [31:0] n);
        rst = r; flush = f; flush_pc = fpc; imem_ready = rdy; id_ready = idr; npc = n;
        imem_rdata = m_discard ? 32'hDEAD_BEEF : mem_word(exp_addr());
        #1;
        chk("imem_req", 32'(imem_req), 32'(exp_req()));
        if (exp_req()) chk("imem_addr", imem_addr, exp_addr());
        chk("pc", pc, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("addr_err", 32'(addr_err), 32'(m_err && m_valid));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = '0; imem_ready = 1'b0;
        id_ready = 1'b0; npc = '0; imem_rdata = '0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0);

        // Zero-wait memory, decode always ready: 2-cycle cadence from 0x3000.
        for (int i = 0; i < 6; i++) drv(0, 0, 0, 1, 1, m_pc + 32'd4);
        chk("cadence_pc", pc, 32'h0000_300C);

        // Memory ready delayed 3 cycles, then HOLD with decode stalled while npc wanders.
        for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 1, 32'h0000_9000);
        drv(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drv(0, 0, 0, 0, 0, $urandom & 32'hFFFF_FFFC);
        drv(0, 0, 0, 0, 1, 32'h0000_5000);
        chk("consume_npc", pc, 32'h0000_5000);

        // Flush during an outstanding fetch; stale 0xDEADBEEF returns two cycles later.
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 1, 32'h0000_4180, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0);
        chk("post_discard_addr", imem_addr, 32'h0000_4180);
        drv(0, 0, 0, 1, 0, 0);
        chk("redirect_instr_pc", instr_pc, 32'h0000_4180);

        // Flush beats id_ready in HOLD; flush with ready in FETCH drops data.
        drv(0, 1, 32'h0000_6000, 0, 1, 32'h0000_7000);
        chk("flush_over_npc", pc, 32'h0000_6000);
        drv(0, 1, 32'h0000_6100, 1, 0, 0);
        chk("flush_ready_drop", 32'(instr_valid), 32'd0);
        drv(0, 0, 0, 1, 0, 0);

        // Reset in HOLD, then reset in DISCARD.
        drv(1, 0, 0, 0, 0, 0);
        chk("rst_hold_pc", pc, RESET_PC);
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 1, 32'h0000_8000, 0, 0, 0);
        drv(1, 0, 0, 1, 0, 0);
        chk("rst_discard_pc", pc, RESET_PC);

        // Misaligned npc: ignored for addressing, or trapped when the check is built in.
        drv(0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 1, 32'h0000_3002);
        drv(0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 1, 1, 32'h0000_3010);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rn;
            rn = $urandom;
            if ($urandom_range(0, 7) != 0) rn[1:0] = 2'b00;
            drv(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
